key_loader32: RTL and testbench
===============================

KEY_LOADER32 -- requirements
Module: key_loader32

Interface
REQ-001 SHALL have parameter KEY_W, default 32, the locking-key width delivered to the locked adder's keyinput port.
REQ-002 SHALL have parameter ERR_W, default 4, the width of the parity-error counter.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port start_i, input, 1, request to begin a new key frame.
REQ-006 SHALL have port abort_i, input, 1, cancel the frame in progress.
REQ-007 SHALL have port key_bit_i, input, 1, serial key data, LSB first, followed by one parity bit.
REQ-008 SHALL have port key_bit_valid_i, input, 1, key_bit_i is valid this cycle.
REQ-009 SHALL have port ready_o, output, 1, loader accepts a bit this cycle; a beat transfers when valid and ready are both 1.
REQ-010 SHALL have port keyinput_o, output, KEY_W, committed key driven to the locked adder's keyinput.
REQ-011 SHALL have port key_valid_o, output, 1, keyinput_o holds a parity-checked key.
REQ-012 SHALL have port err_o, output, 1, one-cycle pulse on a parity failure.
REQ-013 SHALL have port err_cnt_o, output, ERR_W, saturating count of parity failures.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT and PARITY.
REQ-015 In IDLE, ready_o SHALL be 0; start_i=1 SHALL clear the shadow register and bit counter, clear key_valid_o, and move to SHIFT next cycle.
REQ-016 In SHIFT, ready_o SHALL be 1; each accepted beat SHALL write key_bit_i into shadow bit [count] and increment count (0..KEY_W-1).
REQ-017 The beat accepted at count=KEY_W-1 SHALL move the FSM to PARITY; count SHALL never exceed KEY_W-1.
REQ-018 In PARITY, ready_o SHALL be 1; the accepted beat is the even-parity bit (XOR of shadow and parity bit = 0 means pass).
REQ-019 On pass, on the acceptance edge, the block SHALL load keyinput_o with the shadow value, set key_valid_o=1, and return to IDLE; outputs are visible the cycle after acceptance.
REQ-020 On fail, keyinput_o SHALL remain unchanged, key_valid_o SHALL stay 0, err_o SHALL be 1 for exactly the next cycle, err_cnt_o SHALL increment and saturate at 2^ERR_W-1, and the FSM SHALL return to IDLE.
REQ-021 Cycles with key_bit_valid_i=0 SHALL stall SHIFT/PARITY with no state change; there is no timeout.
REQ-022 start_i outside IDLE SHALL be ignored.
REQ-023 abort_i in SHIFT or PARITY SHALL return to IDLE next cycle, discard the shadow register, leave keyinput_o unchanged, and leave key_valid_o at 0; abort_i has priority over a simultaneous beat.
REQ-024 abort_i in IDLE SHALL have no effect; simultaneous start_i and abort_i in IDLE SHALL start a frame.
REQ-025 keyinput_o SHALL change only on a successful parity commit or on reset.

Reset
REQ-026 On rst_ni=0, state SHALL become IDLE immediately and ready_o, key_valid_o and err_o SHALL be 0, keyinput_o and the shadow register all-zeros, and err_cnt_o 0.
REQ-027 Reset asserted mid-frame SHALL discard the frame, with no err_o pulse and no counter change.
REQ-028 Reset SHALL release cleanly; the first frame may start on the first edge after deassertion.

Structure
REQ-029 Package key_loader_pkg SHALL hold the KEY_W and ERR_W defaults and the FSM state enumeration.
REQ-030 Sub-module key_shift_reg SHALL hold the shadow register, bit counter and running parity; the FSM and output registers SHALL stay in key_loader32.
REQ-031 keyinput_o SHALL connect directly to the adder's 32-bit keyinput with no glue logic.

Verification
REQ-032 Frame 0x094F5C9D, parity 0 -> keyinput_o=0x094F5C9D, key_valid_o=1 the cycle after the parity beat, err_cnt_o=0.
REQ-033 Frame 0x094F5C8D with parity bit 0 (odd total) -> err_o pulses once, err_cnt_o=1, keyinput_o keeps the previous 0x094F5C9D, key_valid_o=0.
REQ-034 Frame 0x094F5C9D with key_bit_valid_i toggled on/off every cycle -> same result as REQ-032, with exactly 33 accepted beats.
REQ-035 abort_i after 20 bits, then a full frame 0x0948EC9D, parity 0 -> keyinput_o=0x0948EC9D, err_cnt_o unchanged.
REQ-036 16 consecutive bad-parity frames -> err_cnt_o saturates at 15; then rst_ni pulse mid-frame -> all outputs 0, no err_o pulse.

Source files
------------

// File: rtl/key_loader_pkg.sv
// key_loader_pkg: shared width defaults and FSM states for the key loader
package key_loader_pkg;
  localparam int KEY_W_DEF = 32;
  localparam int ERR_W_DEF = 4;
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
endpackage

// File: rtl/key_shift_reg.sv
// key_shift_reg: shadow key register, bit counter and running parity
module key_shift_reg
  import key_loader_pkg::*;
#(
  parameter int KEY_W = KEY_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr,
  input  logic             shift,
  input  logic             bit_in,
  output logic [KEY_W-1:0] shadow,
  output logic             last,
  output logic             par
);
  localparam int CW = KEY_W > 1 ? $clog2(KEY_W) : 1;
  logic [CW-1:0] count;
  assign last = count == CW'(KEY_W - 1);
  // count parks at KEY_W-1 once the final data bit lands
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow <= '0;
      count  <= '0;
      par    <= 1'b0;
    end else if (clr) begin
      shadow <= '0;
      count  <= '0;
      par    <= 1'b0;
    end else if (shift) begin
      shadow[count] <= bit_in;
      count         <= last ? count : count + 1'b1;
      par           <= par ^ bit_in;
    end
  end
endmodule

// File: rtl/key_loader32.sv
// key_loader32: serial key loader with even-parity commit into the locked adder keyinput
module key_loader32
  import key_loader_pkg::*;
#(
  parameter int KEY_W = KEY_W_DEF,
  parameter int ERR_W = ERR_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             key_bit_i,
  input  logic             key_bit_valid_i,
  output logic             ready_o,
  output logic [KEY_W-1:0] keyinput_o,
  output logic             key_valid_o,
  output logic             err_o,
  output logic [ERR_W-1:0] err_cnt_o
);
  state_t state, state_nxt;
  logic beat, live, clr, shift, chk, ok, last, par;
  logic [KEY_W-1:0] shadow;
  key_shift_reg #(.KEY_W(KEY_W)) u_sr (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .clr   (clr),
    .shift (shift),
    .bit_in(key_bit_i),
    .shadow(shadow),
    .last  (last),
    .par   (par)
  );
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state == IDLE ? (start_i ? SHIFT : IDLE) :
                abort_i       ? IDLE :
                !beat         ? state :
                state == PARITY ? IDLE :
                last          ? PARITY : SHIFT;
  end
  // abort wins over a same-cycle beat and wipes the partial frame
  always_comb begin
    ready_o = state == SHIFT || state == PARITY;
    beat    = key_bit_valid_i & ready_o;
    live    = beat & ~abort_i;
    clr     = state == IDLE ? start_i : abort_i;
    shift   = live & (state == SHIFT);
    chk     = live & (state == PARITY);
    ok      = ~(par ^ key_bit_i);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      keyinput_o  <= '0;
      key_valid_o <= 1'b0;
      err_o       <= 1'b0;
      err_cnt_o   <= '0;
    end else begin
      err_o       <= chk & ~ok;
      key_valid_o <= (chk & ok) | (key_valid_o & ~(state == IDLE & start_i));
      if (chk & ok) keyinput_o <= shadow;
      if (chk & ~ok & (err_cnt_o != '1)) err_cnt_o <= err_cnt_o + 1'b1;
    end
  end
endmodule

// File: tb/tb_key_loader32.sv
// tb_key_loader32: table-driven, directed and randomized checks of key_loader32
module tb_key_loader32;
  logic        clk_i = 0, rst_ni = 0, start_i = 0, abort_i = 0, key_bit_i = 0, key_bit_valid_i = 0;
  logic        ready_o, key_valid_o, err_o;
  logic [31:0] keyinput_o;
  logic [3:0]  err_cnt_o;
  int passed = 0, total = 0, beats = 0;
  logic [31:0] m_key = 0;
  logic [3:0]  m_cnt = 0;
  logic        m_valid = 0, m_err = 0;

  key_loader32 dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
    .key_bit_i(key_bit_i), .key_bit_valid_i(key_bit_valid_i), .ready_o(ready_o),
    .keyinput_o(keyinput_o), .key_valid_o(key_valid_o), .err_o(err_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) if (rst_ni && key_bit_valid_i && ready_o) beats <= beats + 1;

  typedef struct {
    logic [31:0] key;
    logic        par;
    int          gap;
    int          ab;
    logic        exp_valid;
    logic        exp_err;
    logic [31:0] exp_key;
    logic [3:0]  exp_cnt;
  } vec_t;
  vec_t v[5];

  task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h expected %h", n, a, e);
  endtask

  task automatic cyc();
    @(posedge clk_i); #1;
  endtask

  task automatic frame(input logic [31:0] k, input logic p, input int gap, input int ab);
    logic acc;
    int n;
    start_i = 1;
    abort_i = gap == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
    cyc();
    start_i = 0;
    abort_i = 0;
    m_valid = 0;
    m_err   = 0;
    check("start_ready", ready_o, 1);
    for (int i = 0; i < 33; i++) begin
      n = i == 0 ? 0 : gap == 1 ? 1 : gap == 2 ? $urandom_range(0, 2) : 0;
      for (int j = 0; j < n; j++) begin
        key_bit_i = 1'($urandom);
        start_i   = gap == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
        cyc();
      end
      key_bit_i       = i < 32 ? k[i] : p;
      key_bit_valid_i = 1;
      start_i         = gap == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
      if (i == ab) begin
        abort_i = 1;
        cyc();
        abort_i = 0;
        key_bit_valid_i = 0;
        start_i = 0;
        check("abort_ready", ready_o, 0);
        check("abort_valid", key_valid_o, 0);
        check("abort_key", keyinput_o, m_key);
        check("abort_err", err_o, 0);
        check("abort_cnt", err_cnt_o, m_cnt);
        return;
      end
      acc = ready_o;
      cyc();
      key_bit_valid_i = 0;
      start_i = 0;
      if (!acc) begin
        check("beat_ready", acc, 1);
        return;
      end
    end
    if ((^k ^ p) == 1'b0) begin
      m_key   = k;
      m_valid = 1;
    end else begin
      m_err = 1;
      if (m_cnt != 4'hF) m_cnt++;
    end
    check("end_key", keyinput_o, m_key);
    check("end_valid", key_valid_o, m_valid);
    check("end_err", err_o, m_err);
    check("end_cnt", err_cnt_o, m_cnt);
    check("end_ready", ready_o, 0);
  endtask

  task automatic settle();
    cyc();
    check("err_one_cycle", err_o, 0);
    check("hold_key", keyinput_o, m_key);
    check("hold_valid", key_valid_o, m_valid);
  endtask

  initial begin
    int b0, ab;
    v[0] = '{32'h094F5C9D, 1'b0, 0, -1, 1'b1, 1'b0, 32'h094F5C9D, 4'd0};
    v[1] = '{32'h094F5C8D, 1'b0, 0, -1, 1'b0, 1'b1, 32'h094F5C9D, 4'd1};
    v[2] = '{32'h094F5C9D, 1'b0, 1, -1, 1'b1, 1'b0, 32'h094F5C9D, 4'd1};
    v[3] = '{32'h12345678, 1'b0, 0, 20, 1'b0, 1'b0, 32'h094F5C9D, 4'd1};
    v[4] = '{32'h0948EC9D, 1'b0, 0, -1, 1'b1, 1'b0, 32'h0948EC9D, 4'd1};
    #12;
    check("rst_ready", ready_o, 0);
    check("rst_key", keyinput_o, 0);
    check("rst_valid", key_valid_o, 0);
    check("rst_err", err_o, 0);
    check("rst_cnt", err_cnt_o, 0);
    @(negedge clk_i) rst_ni = 1;
    abort_i = 1;
    cyc();
    abort_i = 0;
    check("idle_abort_ready", ready_o, 0);
    check("idle_abort_valid", key_valid_o, 0);
    for (int i = 0; i < 5; i++) begin
      b0 = beats;
      frame(v[i].key, v[i].par, v[i].gap, v[i].ab);
      check("vec_valid", key_valid_o, v[i].exp_valid);
      check("vec_err", err_o, v[i].exp_err);
      check("vec_key", keyinput_o, v[i].exp_key);
      check("vec_cnt", err_cnt_o, v[i].exp_cnt);
      if (v[i].gap == 1) check("toggle_beats", beats - b0, 33);
      settle();
    end
    for (int i = 0; i < 24; i++) begin
      ab = $urandom_range(0, 4) == 0 ? int'($urandom_range(0, 32)) : -1;
      frame($urandom, 1'($urandom), 2, ab);
      settle();
    end
    for (int i = 0; i < 16; i++) begin
      frame(32'h00000001, 1'b0, 0, -1);
      settle();
    end
    check("sat_cnt", err_cnt_o, 15);
    start_i = 1;
    cyc();
    start_i = 0;
    key_bit_valid_i = 1;
    for (int i = 0; i < 10; i++) begin
      key_bit_i = 1'($urandom);
      cyc();
    end
    #2 rst_ni = 0;
    #1;
    check("mid_rst_ready", ready_o, 0);
    check("mid_rst_key", keyinput_o, 0);
    check("mid_rst_valid", key_valid_o, 0);
    check("mid_rst_err", err_o, 0);
    check("mid_rst_cnt", err_cnt_o, 0);
    key_bit_valid_i = 0;
    m_key = 0;
    m_cnt = 0;
    m_valid = 0;
    @(negedge clk_i) rst_ni = 1;
    frame(32'h094F5C9D, 1'b0, 0, -1);
    check("post_rst_key", keyinput_o, 32'h094F5C9D);
    check("post_rst_cnt", err_cnt_o, 0);
    settle();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
